// File: rtl/ctrl_seq.sv
// Decode stage: turns an opcode/op_ext pair into a registered 26-bit control bundle,
// with stall/flush handshaking, a halt state and a saturating retired-instruction count.
module ctrl_seq #(
    parameter int OPCODE_W = 5,
    parameter int EXT_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [EXT_W-1:0]    op_ext,
    input  logic                stall,
    input  logic                flush,
    output logic                out_valid,
    output logic [25:0]         ctrl_out,
    output logic                illegal,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state, state_next;

    logic [4:0]  op;
    logic [1:0]  ext;
    logic        dec_illegal;
    logic [25:0] dec_bundle;
    logic        accept;
    logic        fire;
    logic        unused_ext;

    logic [1:0] d_dst, d_opb;
    logic [2:0] d_alu;
    logic [3:0] d_aext;
    logic d_halt, d_rw, d_pca, d_pcb, d_beqz, d_bnez, d_bgez, d_bltz;
    logic d_jump, d_cin, d_inva, d_invb, d_sign, d_mw, d_wb;

    assign op         = opcode[4:0];
    assign ext        = op_ext[1:0];
    assign unused_ext = ^op_ext;

    generate
        if (OPCODE_W > 5) begin : g_wide_opcode
            assign dec_illegal = |opcode[OPCODE_W-1:5];
        end else begin : g_narrow_opcode
            assign dec_illegal = 1'b0;
        end
    endgenerate

    // dst: 00 I-format rd, 01 R-format rd, 10 rs, 11 r7. opB: 00 rt, 01 imm5, 10 imm8.
    // alu: 000 add, 001 and, 011 xor, 1xx shift/rotate. alu_op_ext selects set/special results.
    always_comb begin
        d_dst  = 2'b00;
        d_opb  = 2'b00;
        d_alu  = 3'b000;
        d_aext = 4'b0000;
        d_halt = 1'b0;
        d_rw   = 1'b0;
        d_pca  = 1'b0;
        d_pcb  = 1'b0;
        d_beqz = 1'b0;
        d_bnez = 1'b0;
        d_bgez = 1'b0;
        d_bltz = 1'b0;
        d_jump = 1'b0;
        d_cin  = 1'b0;
        d_inva = 1'b0;
        d_invb = 1'b0;
        d_sign = 1'b0;
        d_mw   = 1'b0;
        d_wb   = 1'b0;
        case (op)
            5'b00000: d_halt = 1'b1;
            5'b00100: begin d_jump = 1'b1; d_pcb = 1'b1; d_sign = 1'b1; end
            5'b00101: begin d_jump = 1'b1; d_pca = 1'b1; d_sign = 1'b1; end
            5'b00110: begin d_jump = 1'b1; d_pcb = 1'b1; d_sign = 1'b1; d_rw = 1'b1; d_dst = 2'b11; end
            5'b00111: begin d_jump = 1'b1; d_pca = 1'b1; d_sign = 1'b1; d_rw = 1'b1; d_dst = 2'b11; end
            5'b01000: begin d_opb = 2'b01; d_rw = 1'b1; d_sign = 1'b1; end
            5'b01001: begin d_opb = 2'b01; d_rw = 1'b1; d_sign = 1'b1; d_inva = 1'b1; d_cin = 1'b1; end
            5'b01010: begin d_opb = 2'b01; d_rw = 1'b1; d_alu = 3'b011; end
            5'b01011: begin d_opb = 2'b01; d_rw = 1'b1; d_alu = 3'b001; d_invb = 1'b1; end
            5'b01100: begin d_opb = 2'b10; d_sign = 1'b1; d_beqz = 1'b1; end
            5'b01101: begin d_opb = 2'b10; d_sign = 1'b1; d_bnez = 1'b1; end
            5'b01110: begin d_opb = 2'b10; d_sign = 1'b1; d_bltz = 1'b1; end
            5'b01111: begin d_opb = 2'b10; d_sign = 1'b1; d_bgez = 1'b1; end
            5'b10000: begin d_opb = 2'b01; d_sign = 1'b1; d_mw = 1'b1; end
            5'b10001: begin d_opb = 2'b01; d_sign = 1'b1; d_rw = 1'b1; d_wb = 1'b1; end
            5'b10010: begin d_dst = 2'b10; d_opb = 2'b10; d_aext = 4'b0111; d_rw = 1'b1; end
            5'b10011: begin d_dst = 2'b10; d_opb = 2'b01; d_sign = 1'b1; d_mw = 1'b1; d_rw = 1'b1; end
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                d_opb = 2'b01;
                d_rw  = 1'b1;
                d_alu = {1'b1, op[1:0]};
            end
            5'b11000: begin d_dst = 2'b10; d_opb = 2'b10; d_sign = 1'b1; d_aext = 4'b0110; d_rw = 1'b1; end
            5'b11001: begin d_dst = 2'b01; d_aext = 4'b0101; d_rw = 1'b1; end
            5'b11010: begin d_dst = 2'b01; d_rw = 1'b1; d_alu = {1'b1, ext}; end
            5'b11011: begin
                d_dst = 2'b01;
                d_rw  = 1'b1;
                case (ext)
                    2'b01:   begin d_inva = 1'b1; d_cin = 1'b1; end
                    2'b10:   d_alu = 3'b011;
                    2'b11:   begin d_alu = 3'b001; d_invb = 1'b1; end
                    default: d_alu = 3'b000;
                endcase
            end
            5'b11100: begin d_dst = 2'b01; d_rw = 1'b1; d_invb = 1'b1; d_cin = 1'b1; d_aext = 4'b0001; end
            5'b11101: begin d_dst = 2'b01; d_rw = 1'b1; d_invb = 1'b1; d_cin = 1'b1; d_aext = 4'b0010; end
            5'b11110: begin d_dst = 2'b01; d_rw = 1'b1; d_invb = 1'b1; d_cin = 1'b1; d_aext = 4'b0011; end
            5'b11111: begin d_dst = 2'b01; d_rw = 1'b1; d_aext = 4'b0100; end
            default: d_halt = 1'b0;
        endcase
    end

    assign dec_bundle = dec_illegal ? 26'h0000004 :
        {d_dst, d_opb, d_alu, d_aext, d_halt, d_rw, d_pca, d_pcb,
         d_beqz, d_bnez, d_bgez, d_bltz, d_jump, d_cin, d_inva, d_invb,
         d_sign, d_mw, d_wb};

    assign in_ready = (state == RUN) && !(out_valid && stall);
    assign accept   = in_valid && in_ready && !flush;
    assign fire     = out_valid && !stall && !flush;
    assign halted   = (state == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == RUN && accept && dec_bundle[14]) begin
            state_next = HALTED;
        end
    end

    // Flush beats acceptance; a stalled bundle simply holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_out  <= '0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                ctrl_out  <= dec_bundle;
                illegal   <= dec_illegal;
            end else if (!stall) begin
                out_valid <= 1'b0;
            end
            if (fire && retired != {CNT_W{1'b1}}) begin
                retired <= retired + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: a reference decode table and handshake model predict
// every bundle, in_ready, out_valid, halted and retired value.
module tb_ctrl_seq;

    typedef struct packed {
        logic [1:0] dst;
        logic [1:0] opb;
        logic [2:0] alu;
        logic [3:0] aext;
        logic halt, rw, pca, pcb, beqz, bnez, bgez, bltz;
        logic jump, cin, inva, invb, sign, mw, wb;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  op_ext = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, out_valid, illegal, halted;
    logic [25:0] ctrl_out;
    logic [15:0] retired;
    logic        in_ready2, out_valid2, illegal2, halted2;
    logic [25:0] ctrl_out2;
    logic [1:0]  retired2;

    int checks = 0;
    int errors = 0;

    logic        m_ov = 1'b0;
    logic        m_halted = 1'b0;
    int          m_ret = 0;
    logic [1:0]  m_ret2 = '0;
    logic [26:0] sb[$];

    localparam logic [6:0] OP_ADD  = 7'b0011011;
    localparam logic [6:0] OP_HALT = 7'b0000000;

    always #5 clk = ~clk;

    ctrl_seq #(.OPCODE_W(7), .EXT_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op_ext(op_ext), .stall(stall), .flush(flush),
        .out_valid(out_valid), .ctrl_out(ctrl_out), .illegal(illegal),
        .halted(halted), .retired(retired)
    );

    ctrl_seq #(.OPCODE_W(7), .EXT_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .opcode(opcode), .op_ext(op_ext), .stall(stall), .flush(flush),
        .out_valid(out_valid2), .ctrl_out(ctrl_out2), .illegal(illegal2),
        .halted(halted2), .retired(retired2)
    );

    // Reference control table, returned as {illegal, bundle}.
    function automatic logic [26:0] model_decode(input logic [6:0] op, input logic [2:0] ext);
        bundle_t b;
        b = '0;
        if (op[6:5] != 2'b00) begin
            b.sign = 1'b1;
            return {1'b1, b};
        end
        case (op[4:0])
            5'd0:  b.halt = 1'b1;
            5'd4:  begin b.jump = 1; b.pcb = 1; b.sign = 1; end
            5'd5:  begin b.jump = 1; b.pca = 1; b.sign = 1; end
            5'd6:  begin b.jump = 1; b.pcb = 1; b.sign = 1; b.rw = 1; b.dst = 2'd3; end
            5'd7:  begin b.jump = 1; b.pca = 1; b.sign = 1; b.rw = 1; b.dst = 2'd3; end
            5'd8:  begin b.opb = 2'd1; b.rw = 1; b.sign = 1; end
            5'd9:  begin b.opb = 2'd1; b.rw = 1; b.sign = 1; b.inva = 1; b.cin = 1; end
            5'd10: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd3; end
            5'd11: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd1; b.invb = 1; end
            5'd12: begin b.opb = 2'd2; b.sign = 1; b.beqz = 1; end
            5'd13: begin b.opb = 2'd2; b.sign = 1; b.bnez = 1; end
            5'd14: begin b.opb = 2'd2; b.sign = 1; b.bltz = 1; end
            5'd15: begin b.opb = 2'd2; b.sign = 1; b.bgez = 1; end
            5'd16: begin b.opb = 2'd1; b.sign = 1; b.mw = 1; end
            5'd17: begin b.opb = 2'd1; b.sign = 1; b.rw = 1; b.wb = 1; end
            5'd18: begin b.dst = 2'd2; b.opb = 2'd2; b.aext = 4'd7; b.rw = 1; end
            5'd19: begin b.dst = 2'd2; b.opb = 2'd1; b.sign = 1; b.mw = 1; b.rw = 1; end
            5'd20: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd4; end
            5'd21: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd5; end
            5'd22: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd6; end
            5'd23: begin b.opb = 2'd1; b.rw = 1; b.alu = 3'd7; end
            5'd24: begin b.dst = 2'd2; b.opb = 2'd2; b.sign = 1; b.aext = 4'd6; b.rw = 1; end
            5'd25: begin b.dst = 2'd1; b.aext = 4'd5; b.rw = 1; end
            5'd26: begin b.dst = 2'd1; b.rw = 1; b.alu = 3'd4 + {1'b0, ext[1:0]}; end
            5'd27: begin
                b.dst = 2'd1;
                b.rw = 1;
                if (ext[1:0] == 2'd1) begin b.inva = 1; b.cin = 1; end
                if (ext[1:0] == 2'd2) b.alu = 3'd3;
                if (ext[1:0] == 2'd3) begin b.alu = 3'd1; b.invb = 1; end
            end
            5'd28: begin b.dst = 2'd1; b.rw = 1; b.invb = 1; b.cin = 1; b.aext = 4'd1; end
            5'd29: begin b.dst = 2'd1; b.rw = 1; b.invb = 1; b.cin = 1; b.aext = 4'd2; end
            5'd30: begin b.dst = 2'd1; b.rw = 1; b.invb = 1; b.cin = 1; b.aext = 4'd3; end
            5'd31: begin b.dst = 2'd1; b.rw = 1; b.aext = 4'd4; end
            default: b = '0;
        endcase
        return {1'b0, b};
    endfunction

    task automatic model_clear();
        m_ov = 1'b0;
        m_halted = 1'b0;
        m_ret = 0;
        m_ret2 = '0;
        sb.delete();
    endtask

    task automatic apply_reset(input logic v, input logic st, input logic fl);
        rst = 1'b1;
        in_valid = v;
        stall = st;
        flush = fl;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus with scoreboard push on acceptance and compare on the held bundle.
    task automatic drive_cycle(input logic v, input logic [6:0] op, input logic [2:0] ext,
                               input logic st, input logic fl);
        logic m_ready, acc, fire;
        logic [26:0] e;
        in_valid = v;
        opcode = op;
        op_ext = ext;
        stall = st;
        flush = fl;
        @(negedge clk);
        m_ready = !m_halted && !(m_ov && st);
        checks++;
        if (in_ready !== m_ready) begin
            errors++;
            $display("[TB] FAIL in_ready: got %b expected %b at %0t", in_ready, m_ready, $time);
        end
        if (m_ov) begin
            checks++;
            if ({illegal, ctrl_out} !== sb[0]) begin
                errors++;
                $display("[TB] FAIL bundle: got %b/%h expected %b/%h at %0t",
                         illegal, ctrl_out, sb[0][26], sb[0][25:0], $time);
            end
        end
        acc = v && m_ready && !fl;
        fire = m_ov && !st && !fl;
        if (fire || (fl && m_ov)) void'(sb.pop_front());
        e = model_decode(op, ext);
        if (acc) sb.push_back(e);
        if (fire) begin
            if (m_ret < 65535) m_ret++;
            if (m_ret2 != 2'b11) m_ret2 = m_ret2 + 2'b01;
        end
        if (acc && e[14]) m_halted = 1'b1;
        m_ov = fl ? 1'b0 : (acc ? 1'b1 : (st ? m_ov : 1'b0));
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== m_ov || out_valid2 !== m_ov) begin
            errors++;
            $display("[TB] FAIL out_valid: got %b/%b expected %b at %0t", out_valid, out_valid2, m_ov, $time);
        end
        checks++;
        if (halted !== m_halted) begin
            errors++;
            $display("[TB] FAIL halted: got %b expected %b at %0t", halted, m_halted, $time);
        end
        checks++;
        if (retired !== m_ret[15:0] || retired2 !== m_ret2) begin
            errors++;
            $display("[TB] FAIL retired: got %0d/%0d expected %0d/%0d at %0t",
                     retired, retired2, m_ret, m_ret2, $time);
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 26'h0 || illegal !== 1'b0 ||
            halted !== 1'b0 || retired !== 16'h0 || retired2 !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_state: got ov=%b ctrl=%h ill=%b h=%b r=%0d expected all zero",
                     out_valid, ctrl_out, illegal, halted, retired);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_pipeline();
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, OP_ADD, 3'b000, 1'b0, 1'b0);
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
        checks++;
        if (retired !== 16'd3) begin
            errors++;
            $display("[TB] FAIL pipeline_retired: got %0d expected 3", retired);
        end
    endtask

    task automatic test_stall();
        logic [25:0] held;
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, OP_ADD, 3'b101, 1'b0, 1'b0);
        held = ctrl_out;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 7'b0001000, 3'b000, 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b0 || ctrl_out !== held || retired !== 16'd0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got rdy=%b ctrl=%h r=%0d expected 0/%h/0",
                         in_ready, ctrl_out, retired, held);
            end
        end
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
        checks++;
        if (retired !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stall_release: got %0d expected 1", retired);
        end
    endtask

    task automatic test_halt();
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, OP_HALT, 3'b000, 1'b0, 1'b0);
        checks++;
        if (ctrl_out !== 26'h0004000 || halted !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_enter: got ctrl=%h h=%b rdy=%b expected 0004000/1/0",
                     ctrl_out, halted, in_ready);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, OP_ADD, 3'b000, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || halted !== 1'b1 || retired !== 16'd1) begin
            errors++;
            $display("[TB] FAIL halt_ignore: got ov=%b h=%b r=%0d expected 0/1/1",
                     out_valid, halted, retired);
        end
    endtask

    task automatic test_halt_flush();
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, OP_HALT, 3'b000, 1'b0, 1'b1);
        checks++;
        if (halted !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_flush: got h=%b ov=%b expected 0/0", halted, out_valid);
        end
        drive_cycle(1'b1, OP_ADD, 3'b000, 1'b1, 1'b0);
        drive_cycle(1'b1, OP_ADD, 3'b000, 1'b1, 1'b1);
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        apply_reset(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 7'b0100000, 3'b000, 1'b0, 1'b0);
        checks++;
        if (illegal !== 1'b1 || ctrl_out !== 26'h0000004 || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal: got ill=%b ctrl=%h h=%b expected 1/0000004/0",
                     illegal, ctrl_out, halted);
        end
        drive_cycle(1'b1, 7'b1011011, 3'b000, 1'b0, 1'b0);
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 32; i++) begin
            drive_cycle(1'b1, 7'(i), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        for (int e = 0; e < 8; e++) begin
            drive_cycle(1'b1, 7'b0011010, 3'(e), 1'b0, 1'b0);
            drive_cycle(1'b1, OP_ADD, 3'(e), 1'b0, 1'b0);
        end
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, OP_ADD, 3'b000, 1'b0, 1'b0);
        drive_cycle(1'b0, OP_ADD, 3'b000, 1'b0, 1'b0);
        checks++;
        if (retired2 !== 2'd3 || retired !== 16'd5) begin
            errors++;
            $display("[TB] FAIL saturation: got %0d/%0d expected 3/5", retired2, retired);
        end
        drive_cycle(1'b1, OP_ADD, 3'b000, 1'b0, 1'b0);
        drive_cycle(1'b1, OP_ADD, 3'b000, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 26'h0 || illegal !== 1'b0 || halted !== 1'b0 ||
            retired !== 16'h0 || retired2 !== 2'b00 || out_valid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_stall: got ov=%b ctrl=%h ill=%b h=%b r=%0d/%0d expected zeros",
                     out_valid, ctrl_out, illegal, halted, retired, retired2);
        end
        rst = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_random();
        logic [6:0] op;
        apply_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 250; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) apply_reset(1'b1, 1'b1, 1'b0);
            op = 7'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) op[6:5] = 2'($urandom_range(1, 3));
            if (op == OP_HALT && $urandom_range(0, 1) == 0) op = OP_ADD;
            drive_cycle(1'($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_stall();
        test_halt();
        test_halt_flush();
        test_illegal();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The module SHALL have a parameter OPCODE_W, default 5, giving the opcode width; it SHALL be at least 5.
REQ-002 The module SHALL have a parameter EXT_W, default 2, giving the op_ext width; it SHALL be at least 2.
REQ-003 The module SHALL have a parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  opcode/op_ext present.
REQ-007 in_ready  output  1  stage accepts input this cycle.
REQ-008 opcode  input  OPCODE_W  instruction opcode.
REQ-009 op_ext  input  EXT_W  opcode extension.
REQ-010 stall  input  1  downstream not accepting; holds the output register.
REQ-011 flush  input  1  discard the held and incoming instruction.
REQ-012 out_valid  output  1  control bundle valid.
REQ-013 ctrl_out  output  26  registered control bundle, MSB first, in this order:
- sel_reg_dst[1:0], sel_alu_opB[1:0], alu_op[2:0], alu_op_ext[3:0]
- halt, reg_write, sel_pc_opA, sel_pc_opB, beqz, bnez, bgez, bltz
- jump, Cin, invA, invB, sign, mem_write, sel_wb
REQ-014 illegal  output  1  registered; qualifies ctrl_out; set when opcode[OPCODE_W-1:5] is nonzero.
REQ-015 halted  output  1  the stage is in state HALTED.
REQ-016 retired  output  CNT_W  count of instructions handed downstream.

Function
REQ-017 in_ready SHALL be (state==RUN) && !(out_valid && stall); it SHALL be combinational.
REQ-018 An instruction SHALL be accepted when in_valid && in_ready && !flush.
REQ-019 On acceptance, ctrl_out SHALL load the ISA control-table decode of opcode[4:0]/op_ext[1:0] one cycle later (latency 1), and out_valid SHALL be set.
REQ-020 For an illegal opcode, ctrl_out SHALL be all-zero except sign=1, and illegal=1; the instruction SHALL still be accepted and retired.
REQ-021 When out_valid && stall && !flush, ctrl_out, illegal and out_valid SHALL hold unchanged.
REQ-022 When out_valid && !stall with no new acceptance, out_valid SHALL clear next cycle.
REQ-023 On flush, out_valid SHALL be 0 next cycle, the incoming instruction SHALL be dropped, and retired SHALL NOT increment for the flushed entry; flush SHALL override stall.
REQ-024 The state machine SHALL have states RUN and HALTED.
REQ-025 RUN SHALL go to HALTED on the cycle the halt instruction is accepted (decoded halt=1).
REQ-026 A halt instruction presented with flush SHALL NOT be accepted, and the state SHALL remain RUN.
REQ-027 HALTED SHALL be left only by rst; in HALTED, in_ready SHALL be 0 and the held halt bundle SHALL still drain or flush normally.
REQ-028 retired SHALL increment by 1 each cycle with out_valid && !stall && !flush, and SHALL saturate at all-ones (no wrap).
REQ-029 ctrl_out SHALL ignore op_ext bits above [1:0].

Reset
REQ-030 On rst (any cycle, including mid-stall or while HALTED), the next-cycle state SHALL be: state=RUN, out_valid=0, ctrl_out=0, illegal=0, retired=0, halted=0.
REQ-031 rst SHALL override in_valid, stall and flush.
REQ-032 in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 Pipeline: opcode=5'b11011 with in_valid for 3 consecutive cycles, stall=0 -> out_valid=1 cycles 1-3, retired=3.
REQ-034 Stall: assert stall for 4 cycles with out_valid=1 -> in_ready=0, ctrl_out stable; stall drops -> retired+1 next cycle.
REQ-035 Halt: opcode=5'b00000 accepted -> next cycle halt bit=1, halted=1, in_ready=0; further in_valid ignored until rst.
REQ-036 Halt+flush: opcode=5'b00000 with flush=1 -> halted stays 0, out_valid=0.
REQ-037 Illegal: OPCODE_W=7, opcode=7'b0100000 -> illegal=1, ctrl_out=26'h0000004 (sign only).
REQ-038 Saturation: CNT_W=2 and 5 retirements -> retired=3; rst while stalled -> all outputs zero next cycle.
